// File: rtl/ccff_bitstream_loader.sv
// Streams configuration words MSB-first into the ccff chain head, counts exactly
// CHAIN_LEN shift cycles and folds the bits returning on ccff_tail into a parity.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 28,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              tail_parity
);

  localparam int WL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WL_W-1:0]  FULL_WORD = WL_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WL_W-1:0]   word_left;
  logic              start_ok;
  logic              start_busy;
  logic              accept;

  assign start_ok   = start && !abort && (state == IDLE || state == DONE);
  assign start_busy = start && !abort && (state == LOAD || state == SHIFT);
  assign accept     = cfg_valid && cfg_ready;
  assign ccff_head  = shreg[WORD_W-1];

  // Abort wins over everything; the final chain bit ends the load even mid-word.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nxt = LOAD;
        LOAD:       if (accept) state_nxt = SHIFT;
        SHIFT: begin
          if (bit_cnt == LAST_BIT)               state_nxt = DONE;
          else if (word_left == WL_W'(1))        state_nxt = LOAD;
        end
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      word_left     <= '0;
      cfg_ready     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      tail_parity   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cfg_ready     <= (state_nxt == LOAD);
      ccff_shift_en <= (state_nxt == SHIFT);
      busy          <= (state_nxt == LOAD) || (state_nxt == SHIFT);
      done          <= (state_nxt == DONE);

      if (start_ok) begin
        bit_cnt     <= '0;
        tail_parity <= 1'b0;
        error       <= 1'b0;
      end else if (start_busy) begin
        error <= 1'b1;
      end

      // A shift already under way in the abort cycle still completes.
      if (state == LOAD && accept) begin
        shreg     <= cfg_data;
        word_left <= FULL_WORD;
      end else if (state == SHIFT) begin
        shreg       <= shreg << 1;
        word_left   <= word_left - WL_W'(1);
        bit_cnt     <= bit_cnt + CNT_W'(1);
        tail_parity <= tail_parity ^ ccff_tail;
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: two loaders (28-bit and 70-bit chains) driven with random words,
// a chain model on ccff_tail, and a monitor checking every shifted bit and the parity.
module tb_ccff_bitstream_loader;

  localparam int W = 32;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;

  logic        start_s[2], abort_s[2], valid_s[2], ready_s[2], head_s[2];
  logic        se_s[2], tail_s[2], busy_s[2], done_s[2], err_s[2], tpar_s[2];
  logic [31:0] data_s[2];

  logic [69:0] chain[2];
  logic [69:0] pre_val[2];
  bit          pre_req[2];

  bit          exp_bits[2][$];
  bit          exp_par[2][$];
  logic [31:0] feed_q[2][$];
  int          stall_q[2][$];
  bit          hs_pending[2];

  int shift_cnt[2], ready_cnt[2];
  int base_shift[2], base_ready[2], exp_lat[2], exp_ready[2];
  bit last_par[2];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(28)) u_dut28 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_s[0]), .abort(abort_s[0]),
    .cfg_data(data_s[0]), .cfg_valid(valid_s[0]), .cfg_ready(ready_s[0]),
    .ccff_head(head_s[0]), .ccff_shift_en(se_s[0]), .ccff_tail(tail_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .error(err_s[0]), .tail_parity(tpar_s[0])
  );

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(70)) u_dut70 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_s[1]), .abort(abort_s[1]),
    .cfg_data(data_s[1]), .cfg_valid(valid_s[1]), .cfg_ready(ready_s[1]),
    .ccff_head(head_s[1]), .ccff_shift_en(se_s[1]), .ccff_tail(tail_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .error(err_s[1]), .tail_parity(tpar_s[1])
  );

  assign tail_s[0] = chain[0][27];
  assign tail_s[1] = chain[1][69];

  function automatic int len_of(input int i);
    return (i == 0) ? 28 : 70;
  endfunction

  function automatic logic [69:0] rand70();
    return {6'($urandom), $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic flagFail(input string name, input string what);
    n_checks++;
    $display("[TB] FAIL %s: %s at %0t", name, what, $time);
  endtask

  task automatic step();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic flushEnv(input int i);
    exp_bits[i].delete();
    exp_par[i].delete();
    feed_q[i].delete();
    stall_q[i].delete();
    hs_pending[i] = 1'b0;
    valid_s[i]    = 1'b0;
  endtask

  // Chain bits are the first L bits of the word stream taken MSB-first; parity covers prior contents.
  task automatic applyStimulus(input int i, input logic [31:0] w0, input bit rnd,
                               input int stall_idx, input int stall_n,
                               input bit do_pre, input logic [69:0] pre);
    int          L  = len_of(i);
    int          nw = (L + W - 1) / W;
    int          k  = 0;
    int          st = 0;
    bit          p  = 1'b0;
    logic [31:0] w;
    logic [69:0] mask = (70'(1) << L) - 70'(1);
    exp_bits[i].delete();
    for (int j = 0; j < nw; j++) begin
      w = rnd ? $urandom : w0;
      feed_q[i].push_back(w);
      stall_q[i].push_back((j == stall_idx) ? stall_n : 0);
      if (j == stall_idx) st = stall_n;
      for (int b = W - 1; b >= 0; b--) begin
        if (k < L) begin
          exp_bits[i].push_back(w[b]);
          p ^= w[b];
          k++;
        end
      end
    end
    if (do_pre) begin
      pre_val[i] = pre & mask;
      pre_req[i] = 1'b1;
      exp_par[i].push_back(^(pre & mask));
    end else begin
      exp_par[i].push_back(last_par[i]);
    end
    last_par[i]   = p;
    exp_lat[i]    = L + nw + 1 + st;
    exp_ready[i]  = nw + st;
    base_shift[i] = shift_cnt[i];
    base_ready[i] = ready_cnt[i];
    start_s[i]    = 1'b1;
  endtask

  task automatic waitDone(input int i);
    int n = 0;
    do begin
      step();
      n++;
      start_s[i] = 1'b0;
    end while (!done_s[i] && n < 500);
    if (!done_s[i]) begin
      flagFail("done_timeout", "done never rose");
      flushEnv(i);
    end else begin
      checkOutput("latency", n, exp_lat[i]);
      checkOutput("error_clear", err_s[i], 0);
    end
    repeat (3) step();
    checkOutput("done_held", done_s[i], 1);
    checkOutput("busy_after_done", busy_s[i], 0);
    checkOutput("shift_pulses", shift_cnt[i] - base_shift[i], len_of(i));
    checkOutput("ready_cycles", ready_cnt[i] - base_ready[i], exp_ready[i]);
  endtask

  task automatic waitShifts(input int i, input int target);
    int guard = 0;
    while (shift_cnt[i] - base_shift[i] < target && guard < 200) begin
      step();
      start_s[i] = 1'b0;
      guard++;
    end
    if (shift_cnt[i] - base_shift[i] < target) flagFail("shift_wait", "shift count not reached");
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    logic se_d;
    logic hd_d;
    bit   prev_done;

    // Word feeder: presents queued words, honouring per-word stalls counted in LOAD cycles.
    initial begin
      valid_s[g] = 1'b0;
      data_s[g]  = '0;
      forever begin
        @(negedge prog_clk);
        if (hs_pending[g]) begin
          void'(feed_q[g].pop_front());
          void'(stall_q[g].pop_front());
          valid_s[g]    = 1'b0;
          hs_pending[g] = 1'b0;
        end
        if (!valid_s[g] && feed_q[g].size() > 0) begin
          if (stall_q[g][0] > 0) begin
            if (ready_s[g]) stall_q[g][0] = stall_q[g][0] - 1;
          end else begin
            data_s[g]  = feed_q[g][0];
            valid_s[g] = 1'b1;
          end
        end
        if (valid_s[g] && ready_s[g]) hs_pending[g] = 1'b1;
      end
    end

    // Chain model: applies the shift of the previous posedge half a cycle later.
    initial begin
      chain[g] = '0;
      se_d     = 1'b0;
      hd_d     = 1'b0;
      forever begin
        @(negedge prog_clk);
        if (pre_req[g]) begin
          chain[g]   = pre_val[g];
          pre_req[g] = 1'b0;
        end else if (se_d) begin
          chain[g] = {chain[g][68:0], hd_d};
        end
        se_d = se_s[g];
        hd_d = head_s[g];
      end
    end

    initial begin
      shift_cnt[g] = 0;
      ready_cnt[g] = 0;
      prev_done    = 1'b0;
      forever begin
        @(negedge prog_clk);
        if (se_s[g]) begin
          shift_cnt[g]++;
          if (exp_bits[g].size() == 0) flagFail("extra_shift", "shift_en with no expected bit");
          else checkOutput("ccff_head", head_s[g], exp_bits[g].pop_front());
        end
        if (ready_s[g]) ready_cnt[g]++;
        if (done_s[g] && !prev_done) begin
          if (exp_par[g].size() == 0) flagFail("unexpected_done", "done rose with no load pending");
          else checkOutput("tail_parity", tpar_s[g], exp_par[g].pop_front());
          checkOutput("bits_left", exp_bits[g].size(), 0);
        end
        prev_done = done_s[g];
      end
    end
  end

  initial begin
    #500000;
    flagFail("global_timeout", "simulation ran too long");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i]    = 1'b0;
      abort_s[i]    = 1'b0;
      pre_req[i]    = 1'b0;
      hs_pending[i] = 1'b0;
      last_par[i]   = 1'b0;
    end
    #1 pReset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_cfg_ready", ready_s[i], 0);
      checkOutput("rst_head", head_s[i], 0);
      checkOutput("rst_shift_en", se_s[i], 0);
      checkOutput("rst_busy", busy_s[i], 0);
      checkOutput("rst_done", done_s[i], 0);
      checkOutput("rst_error", err_s[i], 0);
      checkOutput("rst_parity", tpar_s[i], 0);
    end
    step();
    step();
    pReset = 1'b1;
    step();

    applyStimulus(0, 32'hA5A5_A5A5, 1'b0, -1, 0, 1'b1, rand70());
    waitDone(0);

    applyStimulus(0, 32'h0, 1'b0, -1, 0, 1'b1, 70'h7);
    waitDone(0);
    applyStimulus(0, 32'h0, 1'b0, -1, 0, 1'b0, '0);
    waitDone(0);

    applyStimulus(1, 32'h0, 1'b1, -1, 0, 1'b1, rand70());
    waitDone(1);
    applyStimulus(1, 32'h0, 1'b1, 1, 5, 1'b1, rand70());
    waitDone(1);
    applyStimulus(0, 32'h0, 1'b1, 0, 3, 1'b1, rand70());
    waitDone(0);

    applyStimulus(0, 32'h0, 1'b1, -1, 0, 1'b1, rand70());
    waitShifts(0, 11);
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    checkOutput("err_on_busy_start", err_s[0], 1);
    checkOutput("busy_during_shift", busy_s[0], 1);
    waitShifts(0, 16);
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    checkOutput("abort_busy", busy_s[0], 0);
    checkOutput("abort_done", done_s[0], 0);
    checkOutput("abort_ready", ready_s[0], 0);
    checkOutput("abort_shift_en", se_s[0], 0);
    repeat (3) step();
    checkOutput("abort_pulses", shift_cnt[0] - base_shift[0], 16);
    checkOutput("error_sticky", err_s[0], 1);
    flushEnv(0);

    applyStimulus(0, 32'h0, 1'b1, -1, 0, 1'b1, rand70());
    waitShifts(0, 8);
    pReset = 1'b0;
    #1;
    checkOutput("mid_rst_shift_en", se_s[0], 0);
    checkOutput("mid_rst_busy", busy_s[0], 0);
    checkOutput("mid_rst_ready", ready_s[0], 0);
    checkOutput("mid_rst_head", head_s[0], 0);
    checkOutput("mid_rst_done", done_s[0], 0);
    checkOutput("mid_rst_error", err_s[0], 0);
    checkOutput("mid_rst_parity", tpar_s[0], 0);
    flushEnv(0);
    flushEnv(1);
    step();
    pReset = 1'b1;
    step();
    applyStimulus(0, 32'h0, 1'b1, -1, 0, 1'b1, rand70());
    waitDone(0);

    for (int r = 0; r < 8; r++) begin
      int i  = r % 2;
      int nw = (len_of(i) + W - 1) / W;
      applyStimulus(i, 32'h0, 1'b1, int'($urandom_range(0, nw - 1)),
                    int'($urandom_range(0, 4)), 1'b1, rand70());
      waitDone(i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
